// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO offsets,
// STATUS layout and the misalignment rule used by both stores and loads.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;

  localparam int ST_FULL_BIT     = 8;
  localparam int ST_OVERFLOW_BIT = 9;
  localparam int ST_MISALIGN_BIT = 10;

  // Size bits [1:0] alone decide alignment; codes 11 behave like words.
  function automatic logic isMisaligned(input logic [2:0] size, input logic [1:0] addrLo);
    logic result;
    result = 1'b0;
    case (size[1:0])
      2'b01:        result = addrLo[0];
      2'b10, 2'b11: result = (addrLo != 2'b00);
      default:      result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Console transmit FIFO: 8-bit entries, push with drop-on-full reporting,
// valid/ready pop from a registered head slot, occupancy count output.
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               pushData,
  output logic                     full,
  output logic                     dropped,
  output logic [7:0]               headData,
  output logic                     valid,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    slots [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   countQ;
  logic          popNow;
  logic          pushAccept;

  // A pop frees a slot in the same edge, so a push into a full FIFO survives it.
  assign popNow     = valid && ready;
  assign pushAccept = push && (!full || popNow);
  assign dropped    = push && full && !popNow;
  assign valid      = (countQ != '0);
  assign full       = (countQ == FULL_COUNT);
  assign headData   = slots[rdPtr];
  assign count      = countQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= 8'h00;
    end else begin
      if (pushAccept) begin
        slots[wrPtr] <= pushData;
        wrPtr        <= wrPtr + 1'b1;
      end
      if (popNow) rdPtr <= rdPtr + 1'b1;
      case ({pushAccept, popNow})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

endmodule

// File: rtl/data_mem.sv
// M-stage data memory: word RAM with byte/half/word lanes and load extension,
// plus an MMIO window holding the console FIFO and a STATUS/error register.
module data_mem
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [2:0]  mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        misalign_err,
  output logic [31:0] misalign_addr
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      ram [MEM_WORDS];
  logic [IDX_W-1:0] wordIdx;
  logic             isMmio;
  logic [15:0]      offset;
  logic             misaligned;
  logic             ramWrite;
  logic             txPush;
  logic             statusWrite;
  logic             misStore;
  logic [3:0]       laneEn;
  logic [31:0]      laneData;
  logic             overflowQ;
  logic             fifoFull;
  logic             fifoDropped;
  logic [CNT_W-1:0] fifoCount;
  logic [31:0]      statusWord;
  logic [31:0]      rawWord;
  logic [7:0]       laneByte;
  logic [15:0]      laneHalf;

  assign wordIdx     = addr[IDX_W+1:2];
  assign isMmio      = (addr[31:16] == MMIO_BASE[31:16]);
  assign offset      = addr[15:0];
  assign misaligned  = isMisaligned(mem_size, addr[1:0]);
  assign misStore    = mem_write && misaligned;
  assign ramWrite    = mem_write && !misaligned && !isMmio;
  assign txPush      = mem_write && !misaligned && isMmio && (offset == OFF_TXDATA);
  assign statusWrite = mem_write && !misaligned && isMmio && (offset == OFF_STATUS);

  always_comb begin
    laneEn   = 4'b1111;
    laneData = write_data;
    case (mem_size[1:0])
      2'b00: begin
        laneEn   = 4'b0001 << addr[1:0];
        laneData = {4{write_data[7:0]}};
      end
      2'b01: begin
        laneEn   = addr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM is deliberately left unreset; reset only blocks a concurrent store.
  always_ff @(posedge clk) begin
    if (!reset && ramWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (laneEn[i]) ram[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
      end
    end
  end

  console_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (txPush),
    .pushData (write_data[7:0]),
    .full     (fifoFull),
    .dropped  (fifoDropped),
    .headData (console_data),
    .valid    (console_valid),
    .ready    (console_ready),
    .count    (fifoCount)
  );

  // Overflow set is applied last so it would win over a clear in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflowQ     <= 1'b0;
      misalign_err  <= 1'b0;
      misalign_addr <= 32'h0;
    end else begin
      if (misStore) begin
        misalign_err <= 1'b1;
        if (!misalign_err) misalign_addr <= addr;
      end
      if (statusWrite) begin
        overflowQ     <= 1'b0;
        misalign_err  <= 1'b0;
        misalign_addr <= 32'h0;
      end
      if (fifoDropped) overflowQ <= 1'b1;
    end
  end

  always_comb begin
    statusWord                  = 32'h0;
    statusWord[7:0]             = 8'(fifoCount);
    statusWord[ST_FULL_BIT]     = fifoFull;
    statusWord[ST_OVERFLOW_BIT] = overflowQ;
    statusWord[ST_MISALIGN_BIT] = misalign_err;
  end

  always_comb begin
    rawWord = 32'h0;
    if (isMmio) begin
      if (offset == OFF_STATUS) rawWord = statusWord;
    end else begin
      rawWord = ram[wordIdx];
    end
    laneByte = rawWord[8*addr[1:0] +: 8];
    laneHalf = addr[1] ? rawWord[31:16] : rawWord[15:0];
    case (mem_size)
      SZ_B:    read_data = {{24{laneByte[7]}}, laneByte};
      SZ_H:    read_data = {{16{laneHalf[15]}}, laneHalf};
      SZ_BU:   read_data = {24'h0, laneByte};
      SZ_HU:   read_data = {16'h0, laneHalf};
      default: read_data = rawWord;
    endcase
    if (misaligned) read_data = 32'h0;
  end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: a byte-array/queue reference model predicts each
// cycle's outputs; a negedge monitor pops and compares what the DUT presents.
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [2:0]  mem_size;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  data_mem #(.MEM_WORDS(1024), .FIFO_DEPTH(8), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_write     (mem_write),
    .mem_size      (mem_size),
    .addr          (addr),
    .write_data    (write_data),
    .read_data     (read_data),
    .console_data  (console_data),
    .console_valid (console_valid),
    .console_ready (console_ready),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr)
  );

  typedef struct {
    logic [31:0] readData;
    logic        valid;
    logic        err;
    logic [31:0] misAddr;
  } expCycle_t;

  expCycle_t  expQ[$];
  logic [7:0] consoleExpQ[$];

  logic [7:0]  modelMem [4096];
  int          modelCount;
  logic        modelOvf;
  logic        modelErr;
  logic [31:0] modelMisAddr;

  int  errors = 0;
  int  checks = 0;
  logic cycleActive = 1'b0;

  localparam logic [31:0] TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] STATUS = 32'hFFFF_0004;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic modelMisaligned(input logic [2:0] s, input logic [31:0] a);
    int lo;
    lo = int'(a[1:0]);
    if (s[1:0] == 2'b01) return (lo % 2) != 0;
    if (s[1:0] == 2'b10 || s[1:0] == 2'b11) return lo != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] expectedRead(input logic [2:0] s, input logic [31:0] a);
    logic [31:0] word;
    logic [31:0] v;
    int base;
    int sh;
    if (modelMisaligned(s, a)) return 32'h0;
    if (a[31:16] == 16'hFFFF) begin
      word = 32'h0;
      if (a[15:0] == 16'h0004)
        word = modelCount + ((modelCount == 8) ? 256 : 0) + (modelOvf ? 512 : 0) + (modelErr ? 1024 : 0);
    end else begin
      base = int'(a[11:0]) / 4 * 4;
      word = {modelMem[base+3], modelMem[base+2], modelMem[base+1], modelMem[base]};
    end
    sh = int'(a[1:0]);
    case (s)
      3'b000, 3'b100: begin
        v = (word >> (8 * sh)) & 32'hFF;
        if (s == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (word >> (16 * (sh / 2))) & 32'hFFFF;
        if (s == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic void modelEdge(input logic w, input logic [2:0] s, input logic [31:0] a,
                                    input logic [31:0] d, input logic rdy);
    logic pop;
    int nBytes;
    int base;
    pop = (modelCount > 0) && rdy;
    if (w) begin
      if (modelMisaligned(s, a)) begin
        if (!modelErr) modelMisAddr = a;
        modelErr = 1'b1;
      end else if (a[31:16] != 16'hFFFF) begin
        nBytes = (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
        base   = int'(a[11:0]) / nBytes * nBytes;
        for (int k = 0; k < nBytes; k++) modelMem[base + k] = 8'((d >> (8 * k)) & 32'hFF);
      end else if (a[15:0] == 16'h0000) begin
        if (modelCount < 8 || pop) begin
          consoleExpQ.push_back(d[7:0]);
          modelCount++;
        end else begin
          modelOvf = 1'b1;
        end
      end else if (a[15:0] == 16'h0004) begin
        modelOvf = 1'b0;
        modelErr = 1'b0;
        modelMisAddr = 32'h0;
      end
    end
    if (pop) modelCount--;
  endfunction

  // One bus cycle: predict the pre-edge outputs, then advance the model at the edge.
  task automatic applyStimulus(input logic w, input logic [2:0] s, input logic [31:0] a,
                               input logic [31:0] d, input logic rdy);
    expCycle_t e;
    mem_write     = w;
    mem_size      = s;
    addr          = a;
    write_data    = d;
    console_ready = rdy;
    e.readData = expectedRead(s, a);
    e.valid    = (modelCount > 0);
    e.err      = modelErr;
    e.misAddr  = modelMisAddr;
    expQ.push_back(e);
    cycleActive = 1'b1;
    @(posedge clk);
    modelEdge(w, s, a, d, rdy);
    #1;
  endtask

  task automatic doReset();
    cycleActive   = 1'b0;
    reset         = 1'b1;
    mem_write     = 1'b0;
    console_ready = 1'b0;
    @(posedge clk);
    modelCount   = 0;
    modelOvf     = 1'b0;
    modelErr     = 1'b0;
    modelMisAddr = 32'h0;
    consoleExpQ.delete();
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cycleActive) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        expCycle_t e;
        e = expQ.pop_front();
        checkOutput("read_data", read_data, e.readData);
        checkOutput("console_valid", {31'h0, console_valid}, {31'h0, e.valid});
        checkOutput("misalign_err", {31'h0, misalign_err}, {31'h0, e.err});
        checkOutput("misalign_addr", misalign_addr, e.misAddr);
      end
      if (console_valid && console_ready) begin
        if (consoleExpQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL console_data: unexpected pop of 0x%02h", console_data);
        end else begin
          checkOutput("console_data", {24'h0, console_data}, {24'h0, consoleExpQ.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] sizeList [8];
    sizeList = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    reset = 1'b1;
    mem_write = 1'b0;
    mem_size = 3'b010;
    addr = 32'h0;
    write_data = 32'h0;
    console_ready = 1'b0;
    modelCount = 0;
    modelOvf = 1'b0;
    modelErr = 1'b0;
    modelMisAddr = 32'h0;
    for (int i = 0; i < 4096; i++) modelMem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset console_valid", {31'h0, console_valid}, 32'h0);
    checkOutput("reset console_data", {24'h0, console_data}, 32'h0);
    checkOutput("reset misalign_err", {31'h0, misalign_err}, 32'h0);
    checkOutput("reset misalign_addr", misalign_addr, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 3'b010, 32'(i * 4), 32'h0, 1'b0);

    // Store/load mix
    applyStimulus(1'b1, 3'b010, 32'h10, 32'h8000_80FF, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h11, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);

    // Partial stores; the SH cycle itself still reads the old half
    applyStimulus(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h22, 32'h0000_1234, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);

    // Misalignment
    applyStimulus(1'b1, 3'b010, 32'h41, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h43, 32'h5555, 1'b0);
    applyStimulus(1'b0, 3'b010, STATUS, 32'h0, 1'b0);
    applyStimulus(1'b1, 3'b010, STATUS, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b010, STATUS, 32'h0, 1'b0);

    // FIFO fill with overflow, then drain
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 3'b000, TXDATA, 32'(i), 1'b0);
    applyStimulus(1'b0, 3'b010, STATUS, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'b010, STATUS, 32'h0, 1'b0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'b000, TXDATA, 32'(8'h40 + i), 1'b0);
    applyStimulus(1'b1, 3'b000, TXDATA, 32'h0000_0055, 1'b1);
    applyStimulus(1'b0, 3'b010, STATUS, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 3'b010, STATUS, 32'h0, 1'b1);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b000, TXDATA, 32'(8'h70 + i), 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h31, 32'h0, 1'b0);
    doReset();
    applyStimulus(1'b0, 3'b010, STATUS, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);

    // Randomized mix over RAM and the MMIO window
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [2:0]  s;
      if ($urandom_range(0, 4) == 0)
        a = 32'hFFFF_0000 | 32'(4 * $urandom_range(0, 2));
      else
        a = 32'($urandom_range(0, 255));
      s = sizeList[$urandom_range(0, 7)];
      applyStimulus(1'($urandom_range(0, 1)), s, a, $urandom, 1'($urandom_range(0, 1)));
    end

    cycleActive = 1'b0;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
